// File: rtl/roba_pkg.sv
// Shared types and default widths for the DOWNROBATWO product accumulator.
package roba_pkg;

  localparam int unsigned ROBA_PROD_W = 64;
  localparam int unsigned ROBA_ACC_W  = 72;
  localparam int unsigned ROBA_CNT_W  = 8;

  typedef enum logic [1:0] {
    StIdle,
    StAcc,
    StHold
  } acc_state_t;

endpackage

// File: rtl/roba_sat_add.sv
// Sign-extending accumulator adder with overflow detect.
// ROBA_ACC_SAT_EN defined: clamp to signed max/min on overflow; undefined: wrap, ovf tied 0.
module roba_sat_add
  import roba_pkg::*;
#(
  parameter int unsigned ACC_W = ROBA_ACC_W
) (
  input  logic [ACC_W-1:0]       acc,
  input  logic [ROBA_PROD_W-1:0] prod,
  output logic [ACC_W-1:0]       sum,
  output logic                   ovf
);

  logic [ACC_W-1:0] prod_ext;

  always_comb begin
    prod_ext                  = {ACC_W{prod[ROBA_PROD_W-1]}};
    prod_ext[ROBA_PROD_W-1:0] = prod;
  end

`ifdef ROBA_ACC_SAT_EN
  logic [ACC_W:0] sum_w;

  // One guard bit: the top two bits disagree exactly when the signed sum left the range.
  assign sum_w = {acc[ACC_W-1], acc} + {prod_ext[ACC_W-1], prod_ext};
  assign ovf   = sum_w[ACC_W] ^ sum_w[ACC_W-1];

  always_comb begin
    sum = sum_w[ACC_W-1:0];
    if (ovf) begin
      sum = sum_w[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end
`else
  assign sum = acc + prod_ext;
  assign ovf = 1'b0;
`endif

endmodule

// File: rtl/roba_product_accum.sv
// Frame accumulator for 64-bit signed products with valid/ready in and out.
// Saturation and overflow reporting are enabled by the ROBA_ACC_SAT_EN macro.
module roba_product_accum
  import roba_pkg::*;
#(
  parameter int unsigned ACC_W = ROBA_ACC_W,
  parameter int unsigned CNT_W = ROBA_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ROBA_PROD_W-1:0] in_prod,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_W-1:0]       out_acc,
  output logic [CNT_W-1:0]       out_count,
  output logic                   out_ovf
);

  acc_state_t       state_q;
  logic [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;

  logic [ACC_W-1:0] sum;
  logic             add_ovf;
  logic [CNT_W-1:0] cnt_nxt;
  logic             ovf_nxt;
  logic             accept;
  logic             xfer;

  assign in_ready = (state_q != StHold) || out_ready;
  assign accept   = in_valid && in_ready;
  assign xfer     = out_valid && out_ready;

  // acc_q, cnt_q and ovf_q are zero outside StAcc, so a new frame starts from them unchanged.
  assign cnt_nxt = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
  assign ovf_nxt = ovf_q | add_ovf;

  roba_sat_add #(
    .ACC_W(ACC_W)
  ) u_sat_add (
    .acc (acc_q),
    .prod(in_prod),
    .sum (sum),
    .ovf (add_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else begin
      if (xfer) begin
        out_valid <= 1'b0;
        state_q   <= StIdle;
      end
      // In StHold a beat is only accepted alongside a transfer, so it starts a fresh frame.
      if (accept) begin
        if (in_last) begin
          out_valid <= 1'b1;
          out_acc   <= sum;
          out_count <= cnt_nxt;
          out_ovf   <= ovf_nxt;
          acc_q     <= '0;
          cnt_q     <= '0;
          ovf_q     <= 1'b0;
          state_q   <= StHold;
        end else begin
          acc_q   <= sum;
          cnt_q   <= cnt_nxt;
          ovf_q   <= ovf_nxt;
          state_q <= StAcc;
        end
      end
    end
  end

endmodule

// File: tb/tb_roba_product_accum.sv
// Scoreboard bench for roba_product_accum: default 72-bit instance plus a 64-bit overflow instance.
module tb_roba_product_accum;

  typedef struct {
    logic [71:0] acc;
    logic [7:0]  cnt;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic [63:0] acc;
    logic [7:0]  cnt;
    logic        ovf;
  } exp64_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_last, out_valid, out_ready, out_ovf;
  logic [63:0] in_prod;
  logic [71:0] out_acc;
  logic [7:0]  out_count;

  logic        in_valid64, in_ready64, in_last64, out_valid64, out_ready64, out_ovf64;
  logic [63:0] in_prod64, out_acc64;
  logic [7:0]  out_count64;

  int checks = 0;
  int errors = 0;
  int stalls = 0;

  exp_t   q[$];
  exp64_t q64[$];
  exp_t   e;
  exp64_t e64;

  always #5 clk = ~clk;

  roba_product_accum dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_prod  (in_prod),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_acc  (out_acc),
    .out_count(out_count),
    .out_ovf  (out_ovf)
  );

  roba_product_accum #(
    .ACC_W(64),
    .CNT_W(8)
  ) dut64 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid64),
    .in_ready (in_ready64),
    .in_prod  (in_prod64),
    .in_last  (in_last64),
    .out_valid(out_valid64),
    .out_ready(out_ready64),
    .out_acc  (out_acc64),
    .out_count(out_count64),
    .out_ovf  (out_ovf64)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic void push(input logic [71:0] a, input logic [7:0] c, input logic o);
    exp_t t;
    t.acc = a;
    t.cnt = c;
    t.ovf = o;
    q.push_back(t);
  endfunction

  function automatic void push64(input logic [63:0] a, input logic [7:0] c, input logic o);
    exp64_t t;
    t.acc = a;
    t.cnt = c;
    t.ovf = o;
    q64.push_back(t);
  endfunction

  // Called at posedge+1; returns at posedge+1 after the edge that accepted the beat.
  task automatic send(input logic [63:0] p, input logic l);
    int n;
    in_valid = 1'b1;
    in_prod  = p;
    in_last  = l;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        break;
      end
      stalls++;
      n++;
      if (n > 50) begin
        checks++;
        errors++;
        $display("FAIL send_timeout actual=stalled required=accepted");
        @(posedge clk);
        #1;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send64(input logic [63:0] p, input logic l);
    int n;
    in_valid64 = 1'b1;
    in_prod64  = p;
    in_last64  = l;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready64) begin
        @(posedge clk);
        #1;
        break;
      end
      n++;
      if (n > 50) begin
        checks++;
        errors++;
        $display("FAIL send64_timeout actual=stalled required=accepted");
        @(posedge clk);
        #1;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mon_unexpected actual=acc %0h required=no result", out_acc);
      end else begin
        e = q.pop_front();
        chk("mon_acc", out_acc, e.acc);
        chk("mon_count", out_count, e.cnt);
        chk("mon_ovf", out_ovf, e.ovf);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid64 && out_ready64) begin
      if (q64.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mon64_unexpected actual=acc %0h required=no result", out_acc64);
      end else begin
        e64 = q64.pop_front();
        chk("mon64_acc", out_acc64, e64.acc);
        chk("mon64_count", out_count64, e64.cnt);
        chk("mon64_ovf", out_ovf64, e64.ovf);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_prod = '0; in_last = 1'b0; out_ready = 1'b1;
    in_valid64 = 1'b0; in_prod64 = '0; in_last64 = 1'b0; out_ready64 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_acc", out_acc, 72'd0);
    chk("rst_out_count", out_count, 8'd0);
    chk("rst_out_ovf", out_ovf, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;

    // Three-beat frame, out_valid for exactly one cycle.
    push(72'd98, 8'd3, 1'b0);
    send(64'd5, 1'b0);
    send(-64'sd7, 1'b0);
    send(64'd100, 1'b1);
    in_valid = 1'b0;
    chk("f3_valid_rise", out_valid, 1'b1);
    @(posedge clk);
    #1;
    chk("f3_valid_fall", out_valid, 1'b0);

    // Single-beat frame of -1, visible right after the accepting edge.
    push({72{1'b1}}, 8'd1, 1'b0);
    send({64{1'b1}}, 1'b1);
    in_valid = 1'b0;
    chk("single_latency", out_valid, 1'b1);
    @(posedge clk);
    #1;

    // Back-to-back frames {1,2} and {3}.
    stalls = 0;
    push(72'd3, 8'd2, 1'b0);
    send(64'd1, 1'b0);
    send(64'd2, 1'b1);
    push(72'd3, 8'd1, 1'b0);
    send(64'd3, 1'b1);
    chk("b2b_valid_held", out_valid, 1'b1);
    in_valid = 1'b0;
    chk("b2b_no_stall", stalls, 0);
    @(posedge clk);
    #1;

    // Backpressure: held result, then a beat accepted in the transfer cycle.
    out_ready = 1'b0;
    push(72'd10, 8'd1, 1'b0);
    send(64'd10, 1'b1);
    in_valid = 1'b1; in_prod = 64'd20; in_last = 1'b1;
    push(72'd20, 8'd1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_acc_stable", out_acc, 72'd10);
      chk("bp_valid_held", out_valid, 1'b1);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_new_valid", out_valid, 1'b1);
    chk("bp_new_acc", out_acc, 72'd20);
    @(posedge clk);
    #1;

    // Reset while holding a result discards it.
    out_ready = 1'b0;
    send(64'd7, 1'b1);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("hold_rst_valid", out_valid, 1'b0);
    chk("hold_rst_acc", out_acc, 72'd0);
    out_ready = 1'b1;

    // Reset mid-frame, then a fresh single-beat frame.
    send(64'd50, 1'b0);
    send(64'd60, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    push(72'd4, 8'd1, 1'b0);
    send(64'd4, 1'b1);
    in_valid = 1'b0;
    @(posedge clk);
    #1;

    // 300 beats saturate the 8-bit counter.
    push(72'd300, 8'd255, 1'b0);
    for (int i = 0; i < 299; i++) send(64'd1, 1'b0);
    send(64'd1, 1'b1);
    in_valid = 1'b0;
    @(posedge clk);
    #1;

    // 64-bit accumulator overflow in both directions, then a clean frame.
`ifdef ROBA_ACC_SAT_EN
    push64(64'h7fff_ffff_ffff_ffff, 8'd3, 1'b1);
    push64(64'h8000_0000_0000_0000, 8'd3, 1'b1);
`else
    push64(64'hc000_0000_0000_0000, 8'd3, 1'b0);
    push64(64'h4000_0000_0000_0000, 8'd3, 1'b0);
`endif
    push64(64'd5, 8'd1, 1'b0);
    send64(64'h4000_0000_0000_0000, 1'b0);
    send64(64'h4000_0000_0000_0000, 1'b0);
    send64(64'h4000_0000_0000_0000, 1'b1);
    send64(64'hc000_0000_0000_0000, 1'b0);
    send64(64'hc000_0000_0000_0000, 1'b0);
    send64(64'hc000_0000_0000_0000, 1'b1);
    send64(64'd5, 1'b1);
    in_valid64 = 1'b0;

    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_drained", q.size(), 0);
    chk("scoreboard64_drained", q64.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
